l2_port_arbiter: RTL and testbench

//  Shares the single L2 lower-memory port between N_REQ L1 caches (port 0 = I-cache, port 1 = D-cache).

---
 rtl/l2_arb_pkg.sv | 19 +
 rtl/l2_port_arbiter_rr_pick.sv | 28 ++
 rtl/l2_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_l2_port_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/l2_arb_pkg.sv
// Shared types for the L2 port arbiter and the L1 cache request paths.
// Holds the arbiter state encoding, default L2 widths and the L2 request record.
package l2_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int L2_ADDR_WIDTH = 32;
    localparam int L2_DATA_WIDTH = 32;

    typedef struct packed {
        logic                     we;
        logic [L2_ADDR_WIDTH-1:0] addr;
        logic [L2_DATA_WIDTH-1:0] wdata;
    } l2_req_t;

endpackage

// File: rtl/l2_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above rr_ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   rr_ptr,
    output logic [IDW-1:0]   winner,
    output logic             any_req
);

    // Scan N_REQ positions starting at rr_ptr; the first hit wins.
    always_comb begin
        winner  = {IDW{1'b0}};
        any_req = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!any_req && req[idx]) begin
                winner  = IDW'(idx);
                any_req = 1'b1;
            end else begin
                any_req = any_req;
            end
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 port between N_REQ L1 caches; grant held until l2_ready.
// Optional watchdog enabled by defining L2_ARB_TIMEOUT_EN.
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int ADDR_WIDTH     = L2_ADDR_WIDTH,
    parameter int DATA_WIDTH     = L2_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic                        l2_request,
    output logic                        l2_write_enable,
    output logic [ADDR_WIDTH-1:0]       l2_address,
    output logic [DATA_WIDTH-1:0]       l2_write_data,
    input  logic [DATA_WIDTH-1:0]       l2_response_data,
    input  logic                        l2_ready,
    output logic [$clog2(N_REQ)-1:0]    grant_id,
    output logic                        timeout_err
);

    localparam int IDW = $clog2(N_REQ);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] winner_s;
    logic           any_req_s;
    logic           timeout_hit_s;

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] p);
        if (int'(p) == N_REQ - 1) begin
            return {IDW{1'b0}};
        end else begin
            return IDW'(int'(p) + 1);
        end
    endfunction

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_pick (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_q),
        .winner  (winner_s),
        .any_req (any_req_s)
    );

    assign rsp_data = l2_response_data;
    assign grant_id = grant_q;

`ifdef L2_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;

    // Watchdog counts BUSY cycles without l2_ready; held at zero while idle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == BUSY) begin
            if (!l2_ready) begin
                cnt_d = cnt_q + 16'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit_s = (state_q == BUSY) && !l2_ready && (cnt_q == TIMEOUT_LAST);
    assign timeout_err   = timeout_hit_s;
`else
    assign timeout_hit_s = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // Next-state and L2-side outputs; the granted slice is forwarded live so
    // write data changed mid-grant reaches the L2.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        rr_ptr_d        = rr_ptr_q;
        rsp_ready       = {N_REQ{1'b0}};
        l2_request      = 1'b0;
        l2_write_enable = 1'b0;
        l2_address      = {ADDR_WIDTH{1'b0}};
        l2_write_data   = {DATA_WIDTH{1'b0}};
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    grant_d = winner_s;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                l2_request         = 1'b1;
                l2_write_enable    = req_we[grant_q];
                l2_address         = req_addr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
                l2_write_data      = req_wdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
                rsp_ready[grant_q] = l2_ready;
                if (l2_ready) begin
                    rr_ptr_d = next_ptr(grant_q);
                    state_d  = IDLE;
                end else if (timeout_hit_s) begin
                    rr_ptr_d = next_ptr(grant_q);
                    state_d  = IDLE;
                end else if (!req_valid[grant_q]) begin
                    // Abort leaves the pointer alone so the aborting port keeps its turn.
                    state_d = IDLE;
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= {IDW{1'b0}};
            rr_ptr_q <= {IDW{1'b0}};
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed, table-driven bench for l2_port_arbiter (N_REQ=2, 32-bit); watchdog checks follow L2_ARB_TIMEOUT_EN.
module tb_l2_port_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        l2_request;
    logic        l2_write_enable;
    logic [31:0] l2_address;
    logic [31:0] l2_write_data;
    logic [31:0] l2_response_data;
    logic        l2_ready;
    logic        grant_id;
    logic        timeout_err;

    int checks;
    int errors;

    l2_port_arbiter #(
        .N_REQ          (2),
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .l2_request       (l2_request),
        .l2_write_enable  (l2_write_enable),
        .l2_address       (l2_address),
        .l2_write_data    (l2_write_data),
        .l2_response_data (l2_response_data),
        .l2_ready         (l2_ready),
        .grant_id         (grant_id),
        .timeout_err      (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rv;
        logic [1:0]  we;
        logic [31:0] a0, a1, d0, d1;
        logic        rdy;
        logic [31:0] rd;
        logic        e_req, e_we;
        logic [31:0] e_addr, e_wd;
        logic [1:0]  e_rsp;
        logic        e_gid;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic [1:0] rv, input logic [1:0] we,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic rdy, input logic [31:0] rd,
                                input logic e_req, input logic e_we,
                                input logic [31:0] e_addr, input logic [31:0] e_wd,
                                input logic [1:0] e_rsp, input logic e_gid);
        vec_t v;
        v.rv = rv; v.we = we; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.rdy = rdy; v.rd = rd; v.e_req = e_req; v.e_we = e_we;
        v.e_addr = e_addr; v.e_wd = e_wd; v.e_rsp = e_rsp; v.e_gid = e_gid;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " l2_request"}, {31'd0, l2_request}, 32'd0);
        chk({tag, " l2_write_enable"}, {31'd0, l2_write_enable}, 32'd0);
        chk({tag, " l2_address"}, l2_address, 32'd0);
        chk({tag, " l2_write_data"}, l2_write_data, 32'd0);
        chk({tag, " rsp_ready"}, {30'd0, rsp_ready}, 32'd0);
        chk({tag, " timeout_err"}, {31'd0, timeout_err}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        req_valid = 2'b00;
        req_we = 2'b00;
        req_addr = 64'd0;
        req_wdata = 64'd0;
        l2_response_data = 32'd0;
        l2_ready = 1'b0;

        //        rv     we     a0            a1            d0            d1            rdy   rd            req   we    addr          wd            rsp    gid
        // contention from reset: port 0, then port 1, then port 0 again
        vecs[0]  = mk(2'b11, 2'b10, 32'h0000_0100, 32'h0000_0200, 32'hA0A0_0000, 32'h0000_0011, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        2'b00, 1'b0);
        vecs[1]  = mk(2'b11, 2'b10, 32'h0000_0100, 32'h0000_0200, 32'hA0A0_0000, 32'h0000_0011, 1'b1, 32'h1111_0000, 1'b1, 1'b0, 32'h0000_0100, 32'hA0A0_0000, 2'b01, 1'b0);
        vecs[2]  = mk(2'b10, 2'b10, 32'h0000_0100, 32'h0000_0200, 32'hA0A0_0000, 32'h0000_0011, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        2'b00, 1'b0);
        vecs[3]  = mk(2'b10, 2'b10, 32'h0000_0100, 32'h0000_0200, 32'hA0A0_0000, 32'h0000_0011, 1'b1, 32'h2222_0000, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0011, 2'b10, 1'b1);
        vecs[4]  = mk(2'b11, 2'b10, 32'h0000_0100, 32'h0000_0200, 32'hA0A0_0000, 32'h0000_0011, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        2'b00, 1'b1);
        vecs[5]  = mk(2'b11, 2'b10, 32'h0000_0100, 32'h0000_0200, 32'hA0A0_0000, 32'h0000_0011, 1'b1, 32'h3333_0000, 1'b1, 1'b0, 32'h0000_0100, 32'hA0A0_0000, 2'b01, 1'b0);
        // single read, ready in 3rd BUSY cycle; then ready while idle is ignored
        vecs[6]  = mk(2'b01, 2'b00, 32'h0000_1000, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        2'b00, 1'b0);
        vecs[7]  = mk(2'b01, 2'b00, 32'h0000_1000, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_1000, 32'h0,        2'b00, 1'b0);
        vecs[8]  = mk(2'b01, 2'b00, 32'h0000_1000, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_1000, 32'h0,        2'b00, 1'b0);
        vecs[9]  = mk(2'b01, 2'b00, 32'h0000_1000, 32'h0,        32'h0,        32'h0,        1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_1000, 32'h0,        2'b01, 1'b0);
        vecs[10] = mk(2'b00, 2'b00, 32'h0000_1000, 32'h0,        32'h0,        32'h0,        1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0,        32'h0,        2'b00, 1'b0);
        // port 1 writeback with data changing mid-grant
        vecs[11] = mk(2'b10, 2'b10, 32'h0,        32'h0000_2000, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        2'b00, 1'b0);
        vecs[12] = mk(2'b10, 2'b10, 32'h0,        32'h0000_2000, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_2000, 32'h0,        2'b00, 1'b1);
        vecs[13] = mk(2'b10, 2'b10, 32'h0,        32'h0000_2000, 32'h0,        32'h5A5A_5A5A, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_2000, 32'h5A5A_5A5A, 2'b00, 1'b1);
        vecs[14] = mk(2'b10, 2'b10, 32'h0,        32'h0000_2000, 32'h0,        32'h5A5A_5A5A, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h0000_2000, 32'h5A5A_5A5A, 2'b10, 1'b1);
        vecs[15] = mk(2'b00, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        2'b00, 1'b1);
        // abort by port 0; pointer must stay at 0 so port 0 wins the next tie
        vecs[16] = mk(2'b01, 2'b00, 32'h0000_3000, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        2'b00, 1'b1);
        vecs[17] = mk(2'b01, 2'b00, 32'h0000_3000, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_3000, 32'h0,        2'b00, 1'b0);
        vecs[18] = mk(2'b00, 2'b00, 32'h0000_3000, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_3000, 32'h0,        2'b00, 1'b0);
        vecs[19] = mk(2'b00, 2'b00, 32'h0000_3000, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        2'b00, 1'b0);
        vecs[20] = mk(2'b11, 2'b10, 32'h0000_3000, 32'h0000_4000, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        2'b00, 1'b0);
        vecs[21] = mk(2'b11, 2'b10, 32'h0000_3000, 32'h0000_4000, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_3000, 32'h0,        2'b00, 1'b0);
        vecs[22] = mk(2'b11, 2'b10, 32'h0000_3000, 32'h0000_4000, 32'h0,        32'h0,        1'b1, 32'h0000_0055, 1'b1, 1'b0, 32'h0000_3000, 32'h0,        2'b01, 1'b0);
        vecs[23] = mk(2'b11, 2'b10, 32'h0000_3000, 32'h0000_4000, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        2'b00, 1'b0);

        // reset state
        #12;
        check_idle_outputs("reset");
        chk("reset grant_id", {31'd0, grant_id}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            req_valid        = vecs[i].rv;
            req_we           = vecs[i].we;
            req_addr         = {vecs[i].a1, vecs[i].a0};
            req_wdata        = {vecs[i].d1, vecs[i].d0};
            l2_ready         = vecs[i].rdy;
            l2_response_data = vecs[i].rd;
            #1;
            chk($sformatf("v%0d l2_request", i), {31'd0, l2_request}, {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d l2_write_enable", i), {31'd0, l2_write_enable}, {31'd0, vecs[i].e_we});
            chk($sformatf("v%0d l2_address", i), l2_address, vecs[i].e_addr);
            chk($sformatf("v%0d l2_write_data", i), l2_write_data, vecs[i].e_wd);
            chk($sformatf("v%0d rsp_ready", i), {30'd0, rsp_ready}, {30'd0, vecs[i].e_rsp});
            chk($sformatf("v%0d rsp_data", i), rsp_data, vecs[i].rd);
            chk($sformatf("v%0d grant_id", i), {31'd0, grant_id}, {31'd0, vecs[i].e_gid});
        end

        // port 1 now BUSY; async reset mid-grant, then port 0 must win the tie
        @(negedge clk);
        #1;
        chk("pre-reset l2_request", {31'd0, l2_request}, 32'd1);
        chk("pre-reset grant_id", {31'd0, grant_id}, 32'd1);
        chk("pre-reset l2_address", l2_address, 32'h0000_4000);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("async reset");
        chk("async reset grant_id", {31'd0, grant_id}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("post-reset l2_request", {31'd0, l2_request}, 32'd1);
        chk("post-reset grant_id", {31'd0, grant_id}, 32'd0);
        chk("post-reset l2_address", l2_address, 32'h0000_3000);

`ifdef L2_ARB_TIMEOUT_EN
        // stall: timeout_err in the 8th BUSY cycle, then IDLE, then port 1
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin
                @(negedge clk);
                #1;
            end
            chk($sformatf("stall c%0d timeout_err", c), {31'd0, timeout_err}, (c == 8) ? 32'd1 : 32'd0);
            chk($sformatf("stall c%0d rsp_ready", c), {30'd0, rsp_ready}, 32'd0);
        end
        @(negedge clk);
        #1;
        chk("after timeout l2_request", {31'd0, l2_request}, 32'd0);
        chk("after timeout timeout_err", {31'd0, timeout_err}, 32'd0);
        @(negedge clk);
        #1;
        chk("regrant l2_request", {31'd0, l2_request}, 32'd1);
        chk("regrant grant_id", {31'd0, grant_id}, 32'd1);
`else
        // without the watchdog a stall simply holds the grant
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) begin
                @(negedge clk);
                #1;
            end
            chk($sformatf("stall c%0d l2_request", c), {31'd0, l2_request}, 32'd1);
            chk($sformatf("stall c%0d timeout_err", c), {31'd0, timeout_err}, 32'd0);
        end
`endif

        @(negedge clk);
        l2_ready = 1'b1;
        #1;
        chk("final rsp_ready nonzero", {31'd0, (rsp_ready != 2'b00)}, 32'd1);
        @(negedge clk);
        l2_ready  = 1'b0;
        req_valid = 2'b00;
        #1;
        chk("final idle l2_request", {31'd0, l2_request}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
